pipe_out_block_buffer: RTL
==========================

// Module: pipe_out_block_buffer
// PURPOSE
//  Block-aligned FIFO between user sample logic and a block-throttled pipe-out endpoint on okClk.
//  Accepts 32-bit words via valid/ready and raises ep_ready only when a full BLOCK_SIZE block is stored.
//  Serves the host burst through ep_blockstrobe/ep_read. The endpoint's okEH output joins the okWireOR bus.
// PARAMETERS
//  DEPTH_LOG2   10    FIFO depth = 2**DEPTH_LOG2 words (32-bit)
//  BLOCK_SIZE   256   words per host block; 1 <= BLOCK_SIZE <= 2**DEPTH_LOG2
// PORTS
//  okClk          in   1             host interface clock; the only clock
//  rst_n          in   1             synchronous reset, active low
//  flush          in   1             synchronous clear of FIFO and FSM
//  s_valid        in   1             user word valid
//  s_data         in   32            user word
//  s_ready        out  1             FIFO can accept a word this cycle
//  ep_ready       out  1             full block available (to endpoint)
//  ep_blockstrobe in   1             host block transfer starts
//  ep_read        in   1             host reads one word
//  ep_datain      out  32            word returned to the endpoint
//  level          out  DEPTH_LOG2+1  words stored
//  underflow      out  1             sticky: read while empty during a burst
//  blocks_sent    out  16            completed blocks, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge): pointers, level, FSM=IDLE, s_ready=0, ep_ready=0, ep_datain=0,
//   underflow=0, blocks_sent=0. s_ready=1 on the first cycle after release.
//  flush=1 has the same effect as reset, except that blocks_sent is kept. It overrides every other input that cycle.
//  Write: push when s_valid&&s_ready. s_ready = (level < 2**DEPTH_LOG2), from registered level.
//   When full, s_ready=0 even if a pop occurs in the same cycle. No overwrite ever.
//  level updates on the cycle after push or pop: +1, -1, or unchanged if both occur.
//  Pointers wrap modulo 2**DEPTH_LOG2.
//  FSM (registered):
//   IDLE  : ep_ready=0. Go to READY when level >= BLOCK_SIZE. ep_blockstrobe is ignored.
//   READY : ep_ready=1, first asserted the cycle after the transition condition.
//           ep_blockstrobe -> BURST, rd_cnt=0, ep_ready=0 on the next cycle.
//   BURST : ep_ready=0. Each ep_read increments rd_cnt.
//           On the BLOCK_SIZE-th read: go to IDLE, blocks_sent+1.
//           IDLE re-evaluates level on the next cycle, so back-to-back blocks give ep_ready=0 for >=1 cycle.
//  Read data: ep_read in BURST with level>0 pops mem[rd_ptr].
//   ep_datain is registered and valid exactly 1 cycle after ep_read. It holds its value between reads.
//  ep_read in BURST with level==0: no pop, ep_datain=0 next cycle, underflow<=1, rd_cnt still advances.
//  ep_read outside BURST: ignored (no pop, no rd_cnt change, ep_datain holds).
//  ep_blockstrobe in BURST: ignored.
//  A push and a pop may occur in the same cycle, including level==0 with a simultaneous push.
//   In that case the pop is not served and the read counts as an underflow: no write-through.
//  underflow is cleared only by reset or flush.
//  Memory: simple dual-port, synchronous read, inferable as block RAM.
// TESTING
//  Release reset, idle 3 cycles -> all outputs 0 except s_ready=1; level=0.
//  Push 255 words (BLOCK_SIZE=256) -> ep_ready stays 0.
//   Push word 256 at cycle N -> level=256 at N+1, ep_ready=1 at N+2.
//  Push 0..255, strobe, then 256 reads on consecutive cycles ->
//   ep_datain = 0..255, each 1 cycle after its read; blocks_sent=1; level=0; ep_ready=0.
//  Push 1024 words with s_valid held high (DEPTH_LOG2=10) -> s_ready=0 after 1024 pushes;
//   word 1025 is not accepted; level=1024.
//  Push 10 words, force READY, then strobe and 12 reads -> words 0..9, then 0,0;
//   underflow=1; FSM stays in BURST until read 256.
//  Flush mid-burst after 100 reads -> next cycle: level=0, ep_ready=0, state IDLE, underflow=0,
//   blocks_sent unchanged; the following 256 pushes give a clean block.

Source files
------------

// File: rtl/pipe_out_block_buffer_if.sv
// Word stream in from user logic and block-throttled read port out to the pipe-out endpoint.
// master drives the user data and host strobes; slave is the block buffer.
interface pipe_out_block_buffer_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        ep_ready;
  logic        ep_blockstrobe;
  logic        ep_read;
  logic [31:0] ep_datain;

  modport master (
    output s_valid,
    output s_data,
    output ep_blockstrobe,
    output ep_read,
    input  s_ready,
    input  ep_ready,
    input  ep_datain
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  ep_blockstrobe,
    input  ep_read,
    output s_ready,
    output ep_ready,
    output ep_datain
  );
endinterface

// File: rtl/pipe_out_block_buffer.sv
// Block-aligned FIFO on okClk: advertises ep_ready only once a whole block is stored,
// then serves one host burst of BLOCK_SIZE reads.
module pipe_out_block_buffer #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned BLOCK_SIZE = 256
) (
  input  logic                  okClk,
  input  logic                  rst_n,
  input  logic                  flush,
  pipe_out_block_buffer_if.slave bus,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underflow,
  output logic [15:0]           blocks_sent
);

  localparam int unsigned Depth   = 1 << DEPTH_LOG2;
  localparam int unsigned LastInt = BLOCK_SIZE - 1;
  localparam logic [DEPTH_LOG2:0] DepthCnt = Depth[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] BlockCnt = BLOCK_SIZE[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LastIdx  = LastInt[DEPTH_LOG2:0];

  typedef enum logic [1:0] {StIdle, StReady, StBurst} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [DEPTH_LOG2:0]   rd_cnt_q, rd_cnt_d;
  logic                  s_ready_q;
  logic [31:0]           dout_q;
  logic                  underflow_q;
  logic [15:0]           blocks_q;
  logic [31:0]           mem [Depth];

  logic push, rd_req, pop, last_read, blk_avail;

  assign blk_avail = (level_q >= BlockCnt);
  assign push      = bus.s_valid && s_ready_q;
  assign rd_req    = (state_q == StBurst) && bus.ep_read;
  // An empty FIFO never serves a read, even if a word is being written this same cycle.
  assign pop       = rd_req && (level_q != '0);
  assign last_read = rd_req && (rd_cnt_q == LastIdx);

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (blk_avail) state_d = StReady;
      end
      StReady: begin
        if (bus.ep_blockstrobe) begin
          state_d  = StBurst;
          rd_cnt_d = '0;
        end
      end
      StBurst: begin
        if (bus.ep_read) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (last_read) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge okClk) begin
    if (!rst_n || flush) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_cnt_q    <= '0;
      s_ready_q   <= 1'b0;
      dout_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      level_q  <= level_d;
      // Readiness tracks the level register, so a pop never frees a slot in the same cycle.
      s_ready_q <= (level_d < DepthCnt);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= mem[rd_ptr_q];
      end else if (rd_req) begin
        dout_q      <= '0;
        underflow_q <= 1'b1;
      end
    end
  end

  // Completed-block count survives flush; only reset clears it.
  always_ff @(posedge okClk) begin
    if (!rst_n) begin
      blocks_q <= '0;
    end else if (!flush && last_read) begin
      blocks_q <= blocks_q + 1'b1;
    end
  end

  always_ff @(posedge okClk) begin
    if (push) mem[wr_ptr_q] <= bus.s_data;
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.ep_ready  = (state_q == StReady);
  assign bus.ep_datain = dout_q;
  assign level         = level_q;
  assign underflow     = underflow_q;
  assign blocks_sent   = blocks_q;

endmodule
